// File: rtl/avr_port_sequencer.sv
// avr_port_sequencer: scripted stimulus/check controller for one 8-bit port of
// the AVR model. Commands from a bench-side queue are buffered in a small FIFO
// and executed in order: drive pins, wait, check pins, or poll with a timeout.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//   cmd_op/data/mask/arg      command payload (DRIVE, WAIT, EXPECT, POLL)
//   pin_in                    port pin levels, synchronized internally
//   pin_out, pin_oe           driven value and per-bit drive enable
//   busy                      FIFO non-empty or a command in progress
//   mismatch, timeout         one-cycle failure pulses
//   err_count                 saturating count of mismatch pulses
module avr_port_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ARG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic [7:0]       cmd_mask,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic [7:0]       pin_in,
    output logic [7:0]       pin_out,
    output logic [7:0]       pin_oe,
    output logic             busy,
    output logic             mismatch,
    output logic             timeout,
    output logic [7:0]       err_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 2 + 8 + 8 + ARG_W;

    localparam logic [1:0] OP_DRIVE  = 2'd0;
    localparam logic [1:0] OP_WAIT   = 2'd1;
    localparam logic [1:0] OP_EXPECT = 2'd2;
    localparam logic [1:0] OP_POLL   = 2'd3;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_POLL  = 2'd2
    } state_t;

    // Command FIFO storage, entry layout {op, data, mask, arg}
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;

    state_t           r_state;
    logic [ARG_W-1:0] r_cnt;
    logic [7:0]       r_cur_data;
    logic [7:0]       r_cur_mask;
    logic [7:0]       r_pin_out;
    logic [7:0]       r_pin_oe;
    logic             r_mismatch;
    logic             r_timeout;
    logic [7:0]       r_err_count;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic [1:0]       w_head_op;
    logic [7:0]       w_head_data;
    logic [7:0]       w_head_mask;
    logic [ARG_W-1:0] w_head_arg;
    logic [CNT_W-1:0] w_count_nx;

    state_t           w_state_nx;
    logic [ARG_W-1:0] w_cnt_nx;
    logic [7:0]       w_cur_data_nx;
    logic [7:0]       w_cur_mask_nx;
    logic [7:0]       w_pin_out_nx;
    logic [7:0]       w_pin_oe_nx;
    logic             w_fail;
    logic             w_tmo;
    logic [7:0]       w_err_nx;

    assign cmd_ready = (r_count != CNT_W'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == ST_READY) && (r_count != '0);

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[ENT_W-1 -: 2];
    assign w_head_data = w_head[ARG_W+15 -: 8];
    assign w_head_mask = w_head[ARG_W+7 -: 8];
    assign w_head_arg  = w_head[ARG_W-1:0];

    assign w_count_nx = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FIFO write port; stale entries are harmless since reset clears the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_data, cmd_mask, cmd_arg};
        end
    end

    // Executor state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Executor next-state and next-output logic
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_cur_data_nx = r_cur_data;
        w_cur_mask_nx = r_cur_mask;
        w_pin_out_nx  = r_pin_out;
        w_pin_oe_nx   = r_pin_oe;
        w_fail        = 1'b0;
        w_tmo         = 1'b0;

        case (r_state)
            ST_READY: begin
                if (w_pop) begin
                    case (w_head_op)
                        OP_DRIVE: begin
                            w_pin_out_nx = w_head_data;
                            w_pin_oe_nx  = w_head_mask;
                        end
                        OP_WAIT: begin
                            // WAIT 0/1 costs only the pop edge itself
                            if (w_head_arg > ARG_W'(1)) begin
                                w_state_nx = ST_WAIT;
                                w_cnt_nx   = w_head_arg - ARG_W'(1);
                            end
                        end
                        OP_EXPECT: begin
                            w_fail = (((r_sync2 ^ w_head_data) & w_head_mask) != 8'h00);
                        end
                        default: begin
                            w_state_nx    = ST_POLL;
                            w_cnt_nx      = w_head_arg;
                            w_cur_data_nx = w_head_data;
                            w_cur_mask_nx = w_head_mask;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (r_cnt <= ARG_W'(1)) begin
                    w_state_nx = ST_READY;
                end else begin
                    w_cnt_nx = r_cnt - ARG_W'(1);
                end
            end
            ST_POLL: begin
                // Match wins over expiry; timer of zero means no timeout
                if (((r_sync2 ^ r_cur_data) & r_cur_mask) == 8'h00) begin
                    w_state_nx = ST_READY;
                end else if (r_cnt != '0) begin
                    if (r_cnt == ARG_W'(1)) begin
                        w_fail     = 1'b1;
                        w_tmo      = 1'b1;
                        w_state_nx = ST_READY;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt - ARG_W'(1);
                    end
                end
            end
            default: begin
                w_state_nx = ST_READY;
            end
        endcase

        w_err_nx = r_err_count;
        if (w_fail && (r_err_count != 8'hFF)) begin
            w_err_nx = r_err_count + 8'd1;
        end
    end

    // Datapath, FIFO pointers, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_sync1     <= 8'h00;
            r_sync2     <= 8'h00;
            r_cnt       <= '0;
            r_cur_data  <= 8'h00;
            r_cur_mask  <= 8'h00;
            r_pin_out   <= 8'h00;
            r_pin_oe    <= 8'h00;
            r_mismatch  <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_nx;
            r_sync1     <= pin_in;
            r_sync2     <= r_sync1;
            r_cnt       <= w_cnt_nx;
            r_cur_data  <= w_cur_data_nx;
            r_cur_mask  <= w_cur_mask_nx;
            r_pin_out   <= w_pin_out_nx;
            r_pin_oe    <= w_pin_oe_nx;
            r_mismatch  <= w_fail;
            r_timeout   <= w_tmo;
            r_err_count <= w_err_nx;
            r_busy      <= (w_count_nx != '0) || (w_state_nx != ST_READY);
        end
    end

    assign pin_out   = r_pin_out;
    assign pin_oe    = r_pin_oe;
    assign busy      = r_busy;
    assign mismatch  = r_mismatch;
    assign timeout   = r_timeout;
    assign err_count = r_err_count;

endmodule

// File: doc/avr_port_sequencer.md
# avr_port_sequencer

Scripted stimulus/check controller for one 8-bit AVR model port in the simulation harness. It accepts commands from a bench-side queue and sequences the port over time: it drives pin values and output enables, waits cycle counts, checks pins against expected patterns, and polls for a pin condition with a timeout. One instance sits beside each port (pa, pb, pd) of the MCU model. All instances run on the same clock as the MCU clock generator.

## Interface
Parameters:
- DEPTH, 8: command FIFO entries; power of two, ≥2.
- ARG_W, 16: width of the wait/timeout argument.

Ports:
- clk  in  1  sequencer clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command; equals !full (combinational).
- cmd_op  in  2  0=DRIVE, 1=WAIT, 2=EXPECT, 3=POLL.
- cmd_data  in  8  drive value or expected value.
- cmd_mask  in  8  DRIVE: output-enable pattern; EXPECT/POLL: compare mask.
- cmd_arg  in  ARG_W  WAIT: cycle count; POLL: timeout cycles (0 = none).
- pin_in  in  8  port pin levels from the MCU model.
- pin_out  out  8  value driven onto the port.
- pin_oe  out  8  per-bit drive enable (1 = sequencer drives the bit).
- busy  out  1  FIFO non-empty or a command is executing.
- mismatch  out  1  one-cycle pulse: EXPECT failed or POLL timed out.
- timeout  out  1  one-cycle pulse: POLL timed out.
- err_count  out  8  saturating count of mismatch pulses.

## Operation
- Push happens on an edge where cmd_valid && cmd_ready. The FIFO holds {op, data, mask, arg}.
- pin_in passes through a 2-flop synchronizer (sin). All compares use sin, which lags pin_in by 2 cycles.
- Executor FSM states:
  - READY: pops the FIFO head on any edge where the FIFO is non-empty.
    - DRIVE: pin_out<=data, pin_oe<=mask. Stays READY.
    - EXPECT: if (sin&mask)!=(data&mask), pulse mismatch and increment err_count. Stays READY.
    - WAIT N: N≤1 stays READY. Otherwise go to S_WAIT with counter=N-1.
    - POLL: go to S_POLL with match/timeout logic armed. Timer=arg.
  - S_WAIT: decrement the counter each edge; return to READY when it reaches 1. The next pop occurs exactly N edges after the WAIT pop.
  - S_POLL: each edge, evaluate (sin&mask)==(data&mask).
    - Match: return to READY, no pulse.
    - Else, if arg≠0: decrement the timer. When it reaches 0, pulse timeout and mismatch, increment err_count, and return to READY.
    - arg=0: poll indefinitely.
- Single-cycle ops execute back-to-back, one per edge.
- err_count saturates at 255. Mismatch pulses still occur at saturation.
- Reset values: pin_out=0, pin_oe=0, FIFO empty (cmd_ready=1), READY, busy=0, mismatch=0, timeout=0, err_count=0, sync flops 0.

## Timing
- A command pushed at edge k is popped at edge k+1 at the earliest, when the FIFO was empty and the FSM was READY. Effects of that pop are visible after edge k+1.
- A DRIVE popped at edge e updates pin_out/pin_oe after edge e.
- EXPECT and POLL see pin_in as it was 2 edges earlier. The mismatch/timeout pulse is high during the cycle after the deciding edge.
- POLL with timeout T and no match: timeout pulses after edge e+T. The next pop is at edge e+T+1.
- A match and timer expiry on the same edge resolve as a match: no pulse.
- Push and pop on the same edge are allowed. Count is unchanged. When full, cmd_ready=0, so a push is impossible.
- Reset asserted mid-WAIT or mid-POLL aborts the command, flushes the FIFO and restores all reset values on that edge. The first edge after rst falls may accept a push.
- busy falls on the edge that completes the last command with the FIFO empty.

## Test plan
- Reset, then DRIVE data=0xA5 mask=0x0F at edge k → pin_out=0xA5 and pin_oe=0x0F after edge k+1; busy=0 after edge k+1.
- pin_in tied to 0x3C; EXPECT data=0x3C mask=0xFF, then EXPECT data=0x00 mask=0xF0 → no pulse from the first, one mismatch pulse from the second; err_count=1.
- Push DRIVE 0x01, WAIT 5, DRIVE 0x02 back-to-back → pin_out changes to 0x02 exactly 6 cycles after it changes to 0x01.
- POLL data=0x80 mask=0x80 arg=10; raise pin_in[7] 4 cycles after the pop → FSM returns to READY after edge pop+6, with no pulse. Repeat with pin_in[7] held low → timeout and mismatch pulse after edge pop+10; err_count increments.
- Fill DEPTH=8 entries of WAIT 20 → cmd_ready=0 on the 8th-entry cycle and reasserts after the first pop. Assert rst mid-WAIT → pin_out=0, pin_oe=0, busy=0, cmd_ready=1 after that edge.
- Issue 300 failing EXPECTs → err_count stops at 255 while mismatch keeps pulsing.
